// File: rtl/calc_pkg.sv
// Shared types for the multi-cycle execute stage: ALU op codes, operand source
// selects and the sequencing FSM states.
package calc_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_MUL  = 4'd9,
      OP_DIVU = 4'd10
   } alu_op_e;

   localparam logic [1:0] SRC_A_PC   = 2'd0;
   localparam logic [1:0] SRC_A_INC  = 2'd1;
   localparam logic [1:0] SRC_A_REG  = 2'd2;
   localparam logic [1:0] SRC_A_IMM  = 2'd3;

   localparam logic [1:0] SRC_B_REG  = 2'd0;
   localparam logic [1:0] SRC_B_INC  = 2'd1;
   localparam logic [1:0] SRC_B_IMM  = 2'd2;
   localparam logic [1:0] SRC_B_ZERO = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MUL_RUN = 2'd1,
      ST_DIV_RUN = 2'd2
   } state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational single-cycle ALU (ops 0-8) with flag generation.
// Multiply/divide codes and unused codes yield 0 here.
module calc_alu
   import calc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [SHW-1:0]   shamt;

   assign sum   = {1'b0, a} + {1'b0, b};
   assign diff  = {1'b0, a} - {1'b0, b};
   assign shamt = b[SHW-1:0];

   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (alu_op_e'(op))
         OP_ADD: begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // diff[WIDTH] is the borrow out, i.e. a < b unsigned
            result   = diff[WIDTH-1:0];
            carry    = diff[WIDTH];
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         OP_SRA:  result = $signed(a) >>> shamt;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: result = '0;
      endcase
   end

   assign zero     = (result == '0);
   assign negative = result[WIDTH-1];

endmodule

// File: rtl/calc_unit_mc.sv
// Multi-cycle execute stage: A/B operand registers, source muxes, ALU, ALUOut,
// PCSrc mux and an iterative shift-add multiplier / restoring divider.
//
// state      | meaning
// -----------|---------------------------------------------------------
// ST_IDLE    | waiting for start; single-cycle ops complete here
// ST_MUL_RUN | WIDTH shift-add steps on {acc_hi_q, acc_lo_q}
// ST_DIV_RUN | WIDTH restoring-division steps, quotient shifts into acc_lo_q
module calc_unit_mc
   import calc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int INC   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             ld_ab,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm,
   input  logic [1:0]       alu_src_a,
   input  logic [1:0]       alu_src_b,
   input  logic [3:0]       alu_op,
   input  logic             start,
   input  logic             pc_src,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] alu_mux_out,
   output logic [WIDTH-1:0] b_reg,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int              CW    = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] src_a_val, src_b_val;
   logic [WIDTH-1:0] alu_res;
   logic             alu_zero, alu_neg, alu_carry, alu_ovf;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] opd_q, acc_hi_q, acc_lo_q;
   logic             last_iter, launch_mul, launch_div, launch_single;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
   logic [WIDTH:0]   div_shift, div_diff;
   logic             div_ok;
   logic [WIDTH-1:0] div_hi_n, div_lo_n;

   always_comb begin
      case (alu_src_a)
         SRC_A_PC:  src_a_val = pc;
         SRC_A_INC: src_a_val = INC_W;
         SRC_A_REG: src_a_val = a_reg;
         default:   src_a_val = imm;
      endcase
      case (alu_src_b)
         SRC_B_REG: src_b_val = b_reg;
         SRC_B_INC: src_b_val = INC_W;
         SRC_B_IMM: src_b_val = imm;
         default:   src_b_val = '0;
      endcase
   end

   calc_alu #(.WIDTH(WIDTH)) u_alu (
      .a        (src_a_val),
      .b        (src_b_val),
      .op       (alu_op),
      .result   (alu_res),
      .zero     (alu_zero),
      .negative (alu_neg),
      .carry    (alu_carry),
      .overflow (alu_ovf)
   );

   assign alu_mux_out = pc_src ? alu_out : alu_res;
   assign busy        = (state_q != ST_IDLE);

   assign launch_mul    = start && !busy && (alu_op == OP_MUL);
   assign launch_div    = start && !busy && (alu_op == OP_DIVU);
   assign launch_single = start && !busy && !launch_mul && !launch_div;
   assign last_iter     = (cnt_q == CW'(1));

   // One shift-add step: add multiplicand to the high half when the
   // multiplier LSB is set, then shift the whole 2*WIDTH accumulator right.
   assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
   assign mul_hi_n = mul_sum[WIDTH:1];
   assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

   // A zero divisor always "fits", giving an all-ones quotient and the
   // dividend shifted back out as remainder.
   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opd_q};
   assign div_ok    = (div_shift >= {1'b0, opd_q});
   assign div_hi_n  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_lo_n  = {acc_lo_q[WIDTH-2:0], div_ok};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (launch_mul)      state_d = ST_MUL_RUN;
            else if (launch_div) state_d = ST_DIV_RUN;
         end
         ST_MUL_RUN: if (last_iter) state_d = ST_IDLE;
         ST_DIV_RUN: if (last_iter) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         alu_out  <= '0;
         hi_out   <= '0;
         zero     <= 1'b0;
         negative <= 1'b0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
         cnt_q    <= '0;
         opd_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
      end else begin
         done <= 1'b0;
         if (ld_ab && !busy) begin
            a_reg <= in_a;
            b_reg <= in_b;
         end
         if (launch_single) begin
            alu_out  <= alu_res;
            zero     <= alu_zero;
            negative <= alu_neg;
            carry    <= alu_carry;
            overflow <= alu_ovf;
            done     <= 1'b1;
         end
         if (launch_mul || launch_div) begin
            opd_q    <= src_b_val;
            acc_lo_q <= src_a_val;
            acc_hi_q <= '0;
            cnt_q    <= CW'(WIDTH);
         end
         if (state_q == ST_MUL_RUN) begin
            acc_hi_q <= mul_hi_n;
            acc_lo_q <= mul_lo_n;
            cnt_q    <= cnt_q - CW'(1);
            if (last_iter) begin
               alu_out  <= mul_lo_n;
               hi_out   <= mul_hi_n;
               zero     <= (mul_lo_n == '0);
               negative <= mul_lo_n[WIDTH-1];
               carry    <= (mul_hi_n != '0);
               overflow <= 1'b0;
               done     <= 1'b1;
            end
         end
         if (state_q == ST_DIV_RUN) begin
            acc_hi_q <= div_hi_n;
            acc_lo_q <= div_lo_n;
            cnt_q    <= cnt_q - CW'(1);
            if (last_iter) begin
               alu_out  <= div_lo_n;
               hi_out   <= div_hi_n;
               zero     <= (div_lo_n == '0);
               negative <= div_lo_n[WIDTH-1];
               carry    <= (opd_q == '0);
               overflow <= 1'b0;
               done     <= 1'b1;
            end
         end
      end
   end

endmodule
